oled_frame_sequencer: RTL

Controller that sequences the SSD1306-class OLED panel over a shared byte-level SPI transmit engine (byte + D/C flag, valid/ready). It owns the panel reset timing, replays a fixed init command list, then arbitrates the transmitter between full-frame refreshes streamed from a synchronous framebuffer and single host command bytes. It sits between the system logic and the SPI serializer that drives sclk/sdin/cs/cmd.

---
 rtl/oled_frame_sequencer.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/oled_frame_sequencer.sv
// SSD1306-class OLED sequencer: panel reset timing, init command replay, then
// arbitration between host command bytes and full-frame refreshes.
// Optional build macro OLED_AUTO_REFRESH_EN re-queues a frame after init and after every frame.
module oled_frame_sequencer #(
  parameter int unsigned STARTUP_DELAY = 270000,
  parameter int unsigned COLS          = 128,
  parameter int unsigned PAGES         = 8,
  parameter int unsigned FB_AW         = 10
) (
  input  logic             clk,
  input  logic             rst,
  output logic             res,
  output logic [7:0]       tx_data,
  output logic             tx_dc,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [FB_AW-1:0] fb_addr,
  input  logic [7:0]       fb_data,
  input  logic             frame_req,
  input  logic             cmd_req,
  input  logic [7:0]       cmd_byte,
  output logic             cmd_ack,
  output logic             busy,
  output logic             frame_done
);

  // state    | meaning
  // RST_LOW  | res driven low for STARTUP_DELAY cycles
  // RST_WAIT | res released, settle for STARTUP_DELAY cycles
  // INIT     | replay the 25-byte init command list
  // IDLE     | arbitrate host command vs pending frame
  // HOST_CMD | one host command byte in flight
  // ADDR     | column/page window commands before a frame
  // FB_READ  | address presented, wait out framebuffer latency
  // STREAM   | one framebuffer byte in flight
  typedef enum logic [2:0] {
    RST_LOW, RST_WAIT, INIT, IDLE, HOST_CMD, ADDR, FB_READ, STREAM
  } state_t;

  localparam int unsigned CW = (STARTUP_DELAY > 1) ? $clog2(STARTUP_DELAY) : 1;
  localparam logic [CW-1:0]    DLY_LOAD = CW'(STARTUP_DELAY - 1);
  localparam logic [FB_AW-1:0] FB_LAST  = FB_AW'(COLS * PAGES - 1);
  localparam logic [4:0]       INIT_LAST = 5'd24;
  localparam logic [4:0]       ADDR_LAST = 5'd5;

  function automatic logic [7:0] init_rom(input logic [4:0] i);
    case (i)
      5'd0:  init_rom = 8'hAE;  5'd1:  init_rom = 8'hD5;  5'd2:  init_rom = 8'h80;
      5'd3:  init_rom = 8'hA8;  5'd4:  init_rom = 8'h3F;  5'd5:  init_rom = 8'hD3;
      5'd6:  init_rom = 8'h00;  5'd7:  init_rom = 8'h40;  5'd8:  init_rom = 8'h8D;
      5'd9:  init_rom = 8'h14;  5'd10: init_rom = 8'h20;  5'd11: init_rom = 8'h00;
      5'd12: init_rom = 8'hA1;  5'd13: init_rom = 8'hC8;  5'd14: init_rom = 8'hDA;
      5'd15: init_rom = 8'h12;  5'd16: init_rom = 8'h81;  5'd17: init_rom = 8'hCF;
      5'd18: init_rom = 8'hD9;  5'd19: init_rom = 8'hF1;  5'd20: init_rom = 8'hDB;
      5'd21: init_rom = 8'h40;  5'd22: init_rom = 8'hA4;  5'd23: init_rom = 8'hA6;
      5'd24: init_rom = 8'hAF;
      default: init_rom = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] addr_rom(input logic [4:0] i);
    case (i)
      5'd0:    addr_rom = 8'h21;
      5'd2:    addr_rom = 8'(COLS - 1);
      5'd3:    addr_rom = 8'h22;
      5'd5:    addr_rom = 8'(PAGES - 1);
      default: addr_rom = 8'h00;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [4:0]       idx_q, idx_d;
  logic             res_q, res_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_dc_q, tx_dc_d;
  logic [FB_AW-1:0] fb_addr_q, fb_addr_d;
  logic             rd_wait_q, rd_wait_d;
  logic             frame_done_q, frame_done_d;
  logic             pend_q, pend_d;
  logic             pend_set, pend_clr, accept;

  assign accept = tx_valid_q & tx_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    res_d        = res_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    tx_dc_d      = tx_dc_q;
    fb_addr_d    = fb_addr_q;
    rd_wait_d    = rd_wait_q;
    frame_done_d = 1'b0;
    pend_set     = frame_req;
    pend_clr     = 1'b0;
    case (state_q)
      RST_LOW: begin
        res_d = 1'b0;
        if (cnt_q == '0) begin
          state_d = RST_WAIT;
          cnt_d   = DLY_LOAD;
          res_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RST_WAIT: begin
        if (cnt_q == '0) begin
          state_d    = INIT;
          idx_d      = 5'd0;
          tx_valid_d = 1'b1;
          tx_data_d  = init_rom(5'd0);
          tx_dc_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      INIT: begin
        if (accept) begin
          if (idx_q == INIT_LAST) begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
`ifdef OLED_AUTO_REFRESH_EN
            pend_set   = 1'b1;
`endif
          end else begin
            idx_d     = idx_q + 5'd1;
            tx_data_d = init_rom(idx_q + 5'd1);
          end
        end
      end
      IDLE: begin
        if (cmd_req) begin
          state_d    = HOST_CMD;
          tx_valid_d = 1'b1;
          tx_data_d  = cmd_byte;
          tx_dc_d    = 1'b0;
        end else if (pend_q) begin
          state_d    = ADDR;
          pend_clr   = 1'b1;
          idx_d      = 5'd0;
          tx_valid_d = 1'b1;
          tx_data_d  = addr_rom(5'd0);
          tx_dc_d    = 1'b0;
        end
      end
      HOST_CMD: begin
        if (accept) begin
          state_d    = IDLE;
          tx_valid_d = 1'b0;
        end
      end
      ADDR: begin
        if (accept) begin
          if (idx_q == ADDR_LAST) begin
            state_d    = FB_READ;
            tx_valid_d = 1'b0;
            fb_addr_d  = '0;
            rd_wait_d  = 1'b0;
          end else begin
            idx_d     = idx_q + 5'd1;
            tx_data_d = addr_rom(idx_q + 5'd1);
          end
        end
      end
      FB_READ: begin
        // first cycle presents the address, second captures the RAM output
        if (!rd_wait_q) begin
          rd_wait_d = 1'b1;
        end else begin
          rd_wait_d  = 1'b0;
          state_d    = STREAM;
          tx_valid_d = 1'b1;
          tx_data_d  = fb_data;
          tx_dc_d    = 1'b1;
        end
      end
      STREAM: begin
        if (accept) begin
          tx_valid_d = 1'b0;
          if (fb_addr_q == FB_LAST) begin
            state_d      = IDLE;
            fb_addr_d    = '0;
            frame_done_d = 1'b1;
`ifdef OLED_AUTO_REFRESH_EN
            pend_set     = 1'b1;
`endif
          end else begin
            state_d   = FB_READ;
            fb_addr_d = fb_addr_q + 1'b1;
          end
        end
      end
      default: state_d = RST_LOW;
    endcase
    pend_d = pend_set ? 1'b1 : (pend_clr ? 1'b0 : pend_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RST_LOW;
      cnt_q        <= DLY_LOAD;
      idx_q        <= 5'd0;
      res_q        <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      tx_dc_q      <= 1'b0;
      fb_addr_q    <= '0;
      rd_wait_q    <= 1'b0;
      frame_done_q <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      res_q        <= res_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      tx_dc_q      <= tx_dc_d;
      fb_addr_q    <= fb_addr_d;
      rd_wait_q    <= rd_wait_d;
      frame_done_q <= frame_done_d;
      pend_q       <= pend_d;
    end
  end

  // ack in the acceptance cycle so a host dropping cmd_req on it is never re-served
  assign cmd_ack    = (state_q == HOST_CMD) & accept;
  assign busy       = (state_q != IDLE);
  assign res        = res_q;
  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign tx_dc      = tx_dc_q;
  assign fb_addr    = fb_addr_q;
  assign frame_done = frame_done_q;

endmodule
